// File: rtl/logicnet_input_packer.sv
// rtl/logicnet_input_packer.sv - quantizes signed feature beats to BW-bit codes and packs NUM_FEAT per vector
// Optional saturation counter port sat_cnt is built only when INPUT_PACKER_SAT_CNT_EN is defined.
module logicnet_input_packer #(
  parameter int NUM_FEAT = 4,
  parameter int IN_W     = 16,
  parameter int BW       = 2,
  parameter int SHIFT    = 4,
  parameter int OFFSET   = 2,
  localparam int OUT_W   = NUM_FEAT * BW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             err_len
`ifdef INPUT_PACKER_SAT_CNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic signed [IN_W:0] OFF_X = (IN_W+1)'(OFFSET);
  localparam logic signed [IN_W:0] MAX_X = (IN_W+1)'((1 << BW) - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] slot_q, slot_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             err_q, err_d;

  logic signed [IN_W-1:0] sh;
  logic signed [IN_W:0]   sum;
  logic                   under, over;
  logic [BW-1:0]          code;
  logic                   accept;

  // Sum is one bit wider than the input so shift plus offset never wraps.
  always_comb begin
    sh    = $signed(s_data) >>> SHIFT;
    sum   = $signed({sh[IN_W-1], sh}) + OFF_X;
    under = sum[IN_W];
    over  = !under && (sum > MAX_X);
    if (under)      code = '0;
    else if (over)  code = '1;
    else            code = sum[BW-1:0];
  end

  assign s_ready = (state_q == FILL);
  assign m_valid = (state_q == HOLD);
  assign m_data  = m_data_q;
  assign err_len = err_q;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    m_data_d = m_data_q;
    err_d    = 1'b0;
    if (accept) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        if (idx_q == IDX_W'(k)) slot_d[k*BW +: BW] = code;
      end
      if (idx_q == LAST_IDX) begin
        // Only a completed set of slots ever reaches m_data.
        state_d  = HOLD;
        idx_d    = '0;
        m_data_d = slot_d;
        err_d    = !s_last;
      end else if (s_last) begin
        idx_d = '0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (state_q == HOLD && m_ready) begin
      state_d = FILL;
    end
  end

`ifdef INPUT_PACKER_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (accept && (under || over) && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  assign sat_cnt = sat_cnt_q;
`else
  // Without the counter, clamping only affects the code value.
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      slot_q    <= '0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
`ifdef INPUT_PACKER_SAT_CNT_EN
      sat_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
`ifdef INPUT_PACKER_SAT_CNT_EN
      sat_cnt_q <= sat_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// tb/tb_logicnet_input_packer.sv - directed and randomized-gap bench for logicnet_input_packer
// Sample-level reference model plus literal expectations; sat_cnt checked when INPUT_PACKER_SAT_CNT_EN is defined.
module tb_logicnet_input_packer;
  localparam int NUM_FEAT = 4;
  localparam int IN_W     = 16;
  localparam int BW       = 2;
  localparam int SHIFT    = 4;
  localparam int OFFSET   = 2;
  localparam int OUT_W    = NUM_FEAT * BW;
  localparam int MAXQ     = (1 << BW) - 1;
  localparam int NRAND    = 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_valid, s_ready, s_last;
  logic [IN_W-1:0]  s_data;
  logic             m_valid, m_ready;
  logic [OUT_W-1:0] m_data;
  logic             err_len;
`ifdef INPUT_PACKER_SAT_CNT_EN
  logic [15:0]      sat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_mode = 0;

  logicnet_input_packer dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_len(err_len)
`ifdef INPUT_PACKER_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(input logic [15:0] d, output bit clamped);
    int x, s;
    x = int'($signed(d));
    s = (x >>> SHIFT) + OFFSET;
    clamped = 1'b0;
    if (s < 0) begin clamped = 1'b1; return 0; end
    if (s > MAXQ) begin clamped = 1'b1; return MAXQ; end
    return s;
  endfunction

  // Reference model: collects codes per sample, emits a vector once NUM_FEAT are in.
  bit               m_hold = 0;
  bit               m_err  = 0;
  logic [OUT_W-1:0] m_exp_data = '0;
  int               m_sat = 0;
  int               model_vecs = 0;
  int               dut_hs = 0;
  int               codes[$];

  always @(posedge clk or negedge rst_n) begin
    int q;
    bit c;
    logic [OUT_W-1:0] v;
    if (!rst_n) begin
      m_hold = 0; m_err = 0; m_exp_data = '0; m_sat = 0; codes.delete();
    end else begin
      m_err = 0;
      if (!m_hold) begin
        if (s_valid) begin
          q = quant(s_data, c);
          if (c && m_sat < 65535) m_sat++;
          codes.push_back(q);
          if (codes.size() == NUM_FEAT) begin
            v = '0;
            for (int k = 0; k < NUM_FEAT; k++) v = v | (OUT_W'(codes[k]) << (k * BW));
            m_exp_data = v;
            m_hold = 1;
            m_err = !s_last;
            codes.delete();
            model_vecs++;
          end else if (s_last) begin
            codes.delete();
            m_err = 1;
          end
        end
      end else if (m_ready) begin
        m_hold = 0;
      end
    end
  end

  always @(posedge clk) if (rst_n && m_valid && m_ready) dut_hs++;

  always @(negedge clk) begin
    check("s_ready", s_ready, !m_hold);
    check("m_valid", m_valid, m_hold);
    check("m_data", m_data, m_exp_data);
    check("err_len", err_len, m_err);
`ifdef INPUT_PACKER_SAT_CNT_EN
    check("sat_cnt", sat_cnt, m_sat);
`endif
  end

  task automatic step();
    @(negedge clk);
    if (rand_mode) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    logic was;
    bit done;
    done = 0;
    step();
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int i = 0; i < 200; i++) begin
      was = s_ready;
      @(posedge clk);
      if (was) begin done = 1; break; end
      step();
    end
    check("send_timeout", done, 1);
  endtask

  task automatic send_ref_sample();
    send(16'h0010, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hFFF0, 1'b0);
    send(16'h8000, 1'b1);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_v, base_hs, r, nb;
    logic [15:0] d;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    #2 rst_n = 1'b1;

    send_ref_sample();
    check("t1_valid", m_valid, 1);
    check("t1_data", m_data, 8'h1B);
    check("t1_err", err_len, 0);
    idle();
    check("t1_one_cycle", m_valid, 0);

    m_ready = 1'b0;
    send_ref_sample();
    repeat (5) begin
      check("t2_valid", m_valid, 1);
      check("t2_data", m_data, 8'h1B);
      check("t2_s_ready", s_ready, 0);
      idle();
    end
    m_ready = 1'b1;
    idle();
    check("t2_release", m_valid, 0);

    send(16'h0010, 1'b0);
    send(16'h0000, 1'b1);
    idle();
    check("t3_err", err_len, 1);
    check("t3_no_valid", m_valid, 0);
    idle();
    check("t3_err_clear", err_len, 0);
    check("t3_still_no_valid", m_valid, 0);
    send(16'h0020, 1'b0);
    send(16'hFFE0, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0010, 1'b1);
    idle();
    check("t3_data", m_data, 8'hE3);
    check("t3_valid", m_valid, 1);

    repeat (4) send(16'h7FFF, 1'b0);
    idle();
    check("t4_data", m_data, 8'hFF);
    check("t4_valid", m_valid, 1);
    check("t4_err", err_len, 1);
    idle();

    m_ready = 1'b0;
    send_ref_sample();
    check("t5_hold", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_ready", s_ready, 1);
    idle();
    idle();
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    send_ref_sample();
    check("t5_after_data", m_data, 8'h1B);
    check("t5_after_valid", m_valid, 1);
    idle();

    base_v  = model_vecs;
    base_hs = dut_hs;
    rand_mode = 1;
    for (int s = 0; s < NRAND; s++) begin
      for (int b = 0; b < NUM_FEAT; b++) begin
        nb = $urandom_range(0, 2);
        repeat (nb) idle();
        if ($urandom_range(0, 1) == 1) begin
          d = 16'($urandom_range(0, 65535));
        end else begin
          r = $urandom_range(0, 96) - 48;
          d = r[15:0];
        end
        send(d, (b == NUM_FEAT - 1));
      end
    end
    idle();
    rand_mode = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && m_valid; i++) idle();
    idle();
    check("drain", m_valid, 0);
    check("rand_model_vecs", model_vecs - base_v, NRAND);
    check("rand_dut_handshakes", dut_hs - base_hs, NRAND);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
